divider_for_dynamic_lighting: RTL and testbench

Clock-enable generator for dynamic (multiplexed) seven-segment lighting in the SevenSegDev design. It divides the 40 MHz system clock (25 ns period) down to a single-cycle clock-enable pulse `CEOUT`, by default at 1 kHz. It also keeps a digit-scan index that advances on every enable pulse. Downstream display logic uses `CEOUT` and the index to switch the active digit; no derived clocks are produced.

---
 rtl/sevenseg_pkg.sv | 14 +
 rtl/ce_counter.sv | 36 +++
 rtl/divider_for_dynamic_lighting.sv | 60 ++++++
 tb/tb_divider_for_dynamic_lighting.sv | 111 +++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants for the SevenSegDev display: clock rates and digit count.
package sevenseg_pkg;

  localparam int CLK_HZ      = 40_000_000;
  localparam int SCAN_HZ     = 1000;
  localparam int DIV_DEFAULT = CLK_HZ / SCAN_HZ;
  localparam int NUM_DIGITS  = 4;

  // Bit width needed to hold 0 .. n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ce_counter.sv
// Generic modulo-N counter with a registered terminal-count pulse.
// The count advances on each edge where en is high and wraps N-1 -> 0
// explicitly, so non-power-of-2 moduli never reach an out-of-range state.
module ce_counter
  import sevenseg_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic [cnt_width(N)-1:0] count,
  output logic                    tc
);

  localparam int W = cnt_width(N);
  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic at_last;
  assign at_last = (count == LAST);

  // Count enabled steps; tc is high for the single cycle after the wrap step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      tc <= en && at_last;
      if (en) begin
        count <= at_last ? '0 : count + ONE;
      end
    end
  end

endmodule

// File: rtl/divider_for_dynamic_lighting.sv
// Clock-enable generator for multiplexed seven-segment scanning.
// A free-running prescaler produces a one-cycle CEOUT pulse every DIV clocks;
// a second counter, advanced by that pulse, provides the digit-scan index.
module divider_for_dynamic_lighting
  import sevenseg_pkg::*;
#(
  parameter int DIV    = DIV_DEFAULT,
  parameter int DIGITS = NUM_DIGITS
) (
  input  logic                        CLK,
  input  logic                        RST,
  output logic                        CEOUT,
  output logic [$clog2(DIGITS)-1:0]   DIGIT
);

  // Reject degenerate dividers and digit counts at elaboration.
  generate
    if (DIV < 2) begin : g_bad_div
      $error("divider_for_dynamic_lighting: DIV must be >= 2");
    end
    if (DIGITS < 2) begin : g_bad_digits
      $error("divider_for_dynamic_lighting: DIGITS must be >= 2");
    end
  endgenerate

  logic [cnt_width(DIV)-1:0]    cnt;
  logic [cnt_width(DIGITS)-1:0] digit_cnt;
  logic                         ce;
  logic                         digit_wrap;

  // Prescaler: counts every cycle; its registered terminal pulse is CEOUT.
  ce_counter #(
    .N (DIV)
  ) u_prescaler (
    .clk   (CLK),
    .rst   (RST),
    .en    (1'b1),
    .count (cnt),
    .tc    (ce)
  );

  // Digit counter: steps on each CEOUT cycle, so DIGIT moves one cycle after the pulse.
  ce_counter #(
    .N (DIGITS)
  ) u_digit (
    .clk   (CLK),
    .rst   (RST),
    .en    (ce),
    .count (digit_cnt),
    .tc    (digit_wrap)
  );

  assign CEOUT = ce;
  assign DIGIT = digit_cnt;

  // The raw prescale count and the digit wrap pulse are not needed downstream.
  logic unused;
  assign unused = ^{cnt, digit_wrap};

endmodule

// File: tb/tb_divider_for_dynamic_lighting.sv
// Directed bench for divider_for_dynamic_lighting: four instances with
// different DIV/DIGITS, all sharing one clock and reset.
`timescale 1ns/1ps
module tb_divider_for_dynamic_lighting;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       ce_a, ce_b, ce_c, ce_d;
  logic [1:0] dig_a, dig_b, dig_c, dig_d;

  int vectors = 0;
  int miscompares = 0;

  always #12.5 clk = ~clk;

  divider_for_dynamic_lighting #(.DIV(4), .DIGITS(4)) u_a (
    .CLK(clk), .RST(rst), .CEOUT(ce_a), .DIGIT(dig_a));
  divider_for_dynamic_lighting #(.DIV(4), .DIGITS(3)) u_b (
    .CLK(clk), .RST(rst), .CEOUT(ce_b), .DIGIT(dig_b));
  divider_for_dynamic_lighting #(.DIV(2), .DIGITS(4)) u_c (
    .CLK(clk), .RST(rst), .CEOUT(ce_c), .DIGIT(dig_c));
  divider_for_dynamic_lighting u_d (
    .CLK(clk), .RST(rst), .CEOUT(ce_d), .DIGIT(dig_d));

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " a.CEOUT"}, {31'd0, ce_a}, 32'd0);
    check({tag, " a.DIGIT"}, {30'd0, dig_a}, 32'd0);
    check({tag, " b.DIGIT"}, {30'd0, dig_b}, 32'd0);
    check({tag, " c.CEOUT"}, {31'd0, ce_c}, 32'd0);
    check({tag, " c.DIGIT"}, {30'd0, dig_c}, 32'd0);
    check({tag, " d.CEOUT"}, {31'd0, ce_d}, 32'd0);
    check({tag, " d.DIGIT"}, {30'd0, dig_d}, 32'd0);
  endtask

  // Apply n edges counted from reset release; after edge k CEOUT is high iff
  // k is a multiple of DIV, and DIGIT equals ((k-1)/DIV) mod DIGITS.
  task automatic run_edges(input string tag, input int n, input bit check_small);
    int pulses_a;
    pulses_a = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (check_small) begin
        check($sformatf("%s a.CEOUT k=%0d", tag, k), {31'd0, ce_a}, ((k % 4) == 0) ? 32'd1 : 32'd0);
        check($sformatf("%s a.DIGIT k=%0d", tag, k), {30'd0, dig_a}, 32'(((k - 1) / 4) % 4));
        check($sformatf("%s b.CEOUT k=%0d", tag, k), {31'd0, ce_b}, ((k % 4) == 0) ? 32'd1 : 32'd0);
        check($sformatf("%s b.DIGIT k=%0d", tag, k), {30'd0, dig_b}, 32'(((k - 1) / 4) % 3));
        check($sformatf("%s c.CEOUT k=%0d", tag, k), {31'd0, ce_c}, ((k % 2) == 0) ? 32'd1 : 32'd0);
        check($sformatf("%s c.DIGIT k=%0d", tag, k), {30'd0, dig_c}, 32'(((k - 1) / 2) % 4));
      end
      check($sformatf("%s d.CEOUT k=%0d", tag, k), {31'd0, ce_d}, ((k % 40000) == 0) ? 32'd1 : 32'd0);
      if (k >= 39999) begin
        check($sformatf("%s d.DIGIT k=%0d", tag, k), {30'd0, dig_d}, 32'(((k - 1) / 40000) % 4));
      end
      if (ce_a === 1'b1) pulses_a++;
    end
    if (check_small && n == 40) begin
      check({tag, " a pulse count"}, 32'(pulses_a), 32'd10);
    end
  endtask

  initial begin
    // Reset hold for 100 ns while clocking.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_all_zero($sformatf("reset_hold%0d", i));
    end
    rst = 1'b0;

    // Period, width and digit scan over 40 edges.
    run_edges("run1", 40, 1'b1);

    // Two more edges leave the DIV=4 prescaler at cnt=2 with DIGIT=2.
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("pre_async a.DIGIT", {30'd0, dig_a}, 32'd2);
    check("pre_async c.CEOUT", {31'd0, ce_c}, 32'd1);

    // Async reset between edges clears state without a clock edge.
    #3 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    check_all_zero("async_hold");
    rst = 1'b0;
    run_edges("run2", 12, 1'b1);

    // Default divider: first pulse exactly 40000 cycles after release.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_edges("dflt", 40002, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
